// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and segment encoding for the 7-segment scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef enum logic [0:0] {
        S_GAP   = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index is the hex digit value 0..F.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hBF, 8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'hA7,
        8'hFF, 8'hEF, 8'hF7, 8'hFC, 8'hD8, 8'hDE, 8'hF9, 8'hF1
    };

    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    // True when digit idx and every more significant digit are zero; digit 0 never qualifies.
    function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] idx);
        logic w_zero;
        w_zero = 1'b0;
        case (idx)
            2'd3:    w_zero = (v[15:12] == 4'h0);
            2'd2:    w_zero = (v[15:8]  == 8'h00);
            2'd1:    w_zero = (v[15:4]  == 12'h000);
            default: w_zero = 1'b0;
        endcase
        return w_zero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : scan_tick_gen
//  Description : DIV-cycle slot counter with end-of-gap and end-of-slot strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int DIV     = 100_000,
    parameter int GAP_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    output logic o_gap_end,
    output logic o_slot_end
);
    localparam int            CW         = $clog2(DIV);
    localparam logic [CW-1:0] C_LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] C_GAP_LAST = CW'(GAP_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_gap_end  = (r_cnt == C_GAP_LAST);
    assign o_slot_end = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : 4-digit multiplexed 7-segment scanner with gap blanking and
//                frame-synchronous value loading. SEG7_LEADING_ZERO_BLANK_EN
//                darkens leading zero digits 3..1.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000,
    parameter int GAP_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_i,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [3:0]  blank_mask,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam int DIV = CLK_HZ / SCAN_HZ;

    generate
        if (DIV <= GAP_CYC + 1 || GAP_CYC < 1) begin : g_param_check
            $error("seg7_scan_ctrl: need DIV > GAP_CYC+1 and GAP_CYC >= 1");
        end
    endgenerate

    scan_state_t r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [15:0] r_disp, r_pend;
    logic        r_pend_full, r_ready, r_frame_done;
    logic [7:0]  r_seg, w_seg_nxt;
    logic [3:0]  r_an, w_an_nxt;
    logic        w_gap_end, w_slot_end, w_boundary, w_xfer, w_dark;

    scan_tick_gen #(
        .DIV     (DIV),
        .GAP_CYC (GAP_CYC)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .o_gap_end  (w_gap_end),
        .o_slot_end (w_slot_end)
    );

    assign w_xfer = load_valid && r_ready;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_dark = blank_mask[r_idx] || upper_zero(r_disp, r_idx);
`else
    assign w_dark = blank_mask[r_idx];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_boundary  = 1'b0;
        w_an_nxt    = 4'b0000;
        w_seg_nxt   = SEG_BLANK;
        case (r_state)
            S_GAP: begin
                if (w_gap_end) w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_an_nxt = 4'b0001 << r_idx;
                if (!w_dark) w_seg_nxt = SEG_TABLE[nibble_sel(r_disp, r_idx)];
                if (w_slot_end) begin
                    w_state_nxt = S_GAP;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_boundary  = (r_idx == 2'd3);
                end
            end
            default: w_state_nxt = S_GAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_GAP;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A transfer in the boundary cycle lands in pending, never straight in display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp       <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pend_full  <= 1'b0;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_an         <= 4'b0000;
        end else begin
            if (w_boundary && r_pend_full) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end
            if (w_xfer) begin
                r_pend      <= value_i;
                r_pend_full <= 1'b1;
            end
            r_ready      <= !((r_pend_full && !w_boundary) || w_xfer);
            r_frame_done <= w_boundary;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
        end
    end

    assign load_ready = r_ready;
    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (DIV=10, GAP_CYC=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 100;
    localparam int GAP     = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_i = 16'h0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [3:0]  blank_mask = 4'h0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .value_i(value_i), .load_valid(load_valid),
        .load_ready(load_ready), .blank_mask(blank_mask), .seg(seg), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       mask;
        logic [3:0][7:0]  exp;   // exp[i] = seg expected on digit i
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: k counts rising edges since reset release.
    int          k;
    logic [15:0] m_disp, m_pend;
    bit          m_pend_full, m_ready, last_xfer;
    logic [7:0]  seg_ref [16];
    logic [3:0][7:0] obs;
    logic [3:0]      seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    function automatic bit tb_dark(input logic [15:0] d, input int i, input logic [3:0] m);
        if (m[i]) return 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (i > 0 && (d >> (4 * i)) == 16'h0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        k = 0; m_disp = 16'h0; m_pend = 16'h0; m_pend_full = 0; m_ready = 0;
    endtask

    // One clock: predict outputs from pre-edge state, advance model, compare after edge.
    task automatic step();
        int c, idx;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        bit e_fd, xfer;
        k++;
        c   = (k - 1) % DIV;
        idx = ((k - 1) / DIV) % 4;
        e_an = 4'b0000; e_seg = 8'h00;
        if (c >= GAP) begin
            e_an = 4'(1 << idx);
            if (!tb_dark(m_disp, idx, blank_mask))
                e_seg = seg_ref[int'((m_disp >> (4 * idx)) & 16'hF)];
        end
        xfer = load_valid && m_ready;
        e_fd = (k % FRAME == 0);
        if (e_fd && m_pend_full) begin
            m_disp = m_pend; m_pend_full = 0;
        end
        if (xfer) begin
            m_pend = value_i; m_pend_full = 1;
        end
        m_ready = !m_pend_full;
        last_xfer = xfer;
        @(posedge clk); #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("load_ready", 32'(load_ready), 32'(m_ready));
        for (int i = 0; i < 4; i++)
            if (an == 4'(1 << i)) begin obs[i] = seg; seen[i] = 1'b1; end
    endtask

    task automatic observe(input int n, input logic [3:0][7:0] e, input string tag);
        seen = 4'b0;
        repeat (n) step();
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_digit%0d", tag, i), {23'h0, seen[i], obs[i]}, {23'h0, 1'b1, e[i]});
    endtask

    task automatic load(input logic [15:0] v);
        int n;
        load_valid = 1'b1; value_i = v; n = 0;
        step();
        while (!last_xfer && n < 200) begin step(); n++; end
        if (!last_xfer) chk("load_timeout", 32'd0, 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic to_boundary();
        while (k % FRAME != 0) step();
    endtask

    vec_t vecs [6];
    logic [3:0][7:0] e_zero, e_1111, e_2222, e_00c0;

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d actual=running required=finished", k);
        $fatal(1, "watchdog");
    end

    initial begin
        seg_ref = '{8'hBF, 8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'hA7,
                    8'hFF, 8'hEF, 8'hF7, 8'hFC, 8'hD8, 8'hDE, 8'hF9, 8'hF1};
        e_1111 = {8'h86, 8'h86, 8'h86, 8'h86};
        e_2222 = {8'hDB, 8'hDB, 8'hDB, 8'hDB};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        e_zero = {8'h00, 8'h00, 8'h00, 8'hBF};
        e_00c0 = {8'h00, 8'h00, 8'hD8, 8'hBF};
        vecs[2] = '{16'h0005, 4'b0000, {8'h00, 8'h00, 8'h00, 8'hED}};
        vecs[5] = '{16'h0B07, 4'b0000, {8'h00, 8'hFC, 8'hBF, 8'hA7}};
`else
        e_zero = {8'hBF, 8'hBF, 8'hBF, 8'hBF};
        e_00c0 = {8'hBF, 8'hBF, 8'hD8, 8'hBF};
        vecs[2] = '{16'h0005, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hED}};
        vecs[5] = '{16'h0B07, 4'b0000, {8'hBF, 8'hFC, 8'hBF, 8'hA7}};
`endif
        vecs[0] = '{16'h12AF, 4'b0000, {8'h86, 8'hDB, 8'hF7, 8'hF1}};
        vecs[1] = '{16'h8888, 4'b0100, {8'hFF, 8'h00, 8'hFF, 8'hFF}};
        vecs[3] = '{16'h3C4E, 4'b1001, {8'h00, 8'hD8, 8'hE6, 8'h00}};
        vecs[4] = '{16'h0000, 4'b0000, e_zero};

        // Reset held three cycles
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk) rst = 1'b0;
        observe(FRAME, e_zero, "post_reset");

        // Table of values and masks
        foreach (vecs[i]) begin
            blank_mask = vecs[i].mask;
            load(vecs[i].value);
            to_boundary();
            observe(FRAME, vecs[i].exp, $sformatf("vec%0d", i));
        end
        blank_mask = 4'b0000;

        // Back-to-back loads: second stalls until the first is applied
        load(16'h1111);
        load(16'h2222);
        observe(FRAME - (k % FRAME), e_1111, "hold1111");
        observe(FRAME, e_2222, "show2222");

        // Transfer exactly on the boundary cycle
        while (k % FRAME != FRAME - 1) step();
        load_valid = 1'b1; value_i = 16'h00C0;
        step();
        chk("bnd_xfer", 32'(last_xfer), 32'd1);
        load_valid = 1'b0;
        observe(FRAME, e_2222, "bnd_prev");
        observe(FRAME, e_00c0, "bnd_new");

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) blank_mask = 4'($urandom);
            load_valid = ($urandom_range(0, 2) == 0);
            value_i = 16'($urandom);
            step();
        end
        load_valid = 1'b0; blank_mask = 4'b0000;

        // Reset mid-slot of digit 2 with pending full
        to_boundary();
        load(16'hBEEF);
        while ((k - 1) % FRAME != 2 * DIV + 5) step();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_an", 32'(an), 32'h0);
        chk("mid_rst_seg", 32'(seg), 32'h0);
        chk("mid_rst_ready", 32'(load_ready), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        observe(FRAME, e_zero, "rst_frame1");
        observe(FRAME, e_zero, "rst_frame2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
